window_mac_unit: RTL

WINDOW_MAC_UNIT -- requirements
Module: window_mac_unit

---
 rtl/ttpu_pkg.sv | 20 ++
 rtl/window_mac_unit_if.sv | 35 +++
 rtl/mac_lane.sv | 64 ++++++
 rtl/window_mac_unit.sv | 106 ++++++++++
 4 files changed

// File: rtl/ttpu_pkg.sv
// Shared definitions for the tiny-TPU datapath blocks: default widths, the
// window MAC state enum and the accumulator sizing rule.
package ttpu_pkg;

  localparam int unsigned DefDataWidth    = 16;
  localparam int unsigned DefMaxKernelDim = 8;

  typedef enum logic [1:0] {
    StIdle,
    StAccum,
    StDone
  } mac_state_e;

  // Room for K*K full-precision products at the largest kernel, with no overflow.
  function automatic int unsigned acc_width(input int unsigned data_width,
                                            input int unsigned max_kernel_dim);
    return 2 * data_width + 2 * $clog2(max_kernel_dim);
  endfunction

endpackage

// File: rtl/window_mac_unit_if.sv
// Control, weight-load and pixel/result handshake bundle of window_mac_unit.
// The unit itself connects to the slave modport; the driver uses master.
interface window_mac_unit_if import ttpu_pkg::*; #(
  parameter int unsigned DATA_WIDTH     = DefDataWidth,
  parameter int unsigned NUM_UNITS      = 2,
  parameter int unsigned MAX_KERNEL_DIM = DefMaxKernelDim
) ();

  localparam int unsigned KDIM_W = $clog2(MAX_KERNEL_DIM) + 1;
  localparam int unsigned ADDR_W = $clog2(MAX_KERNEL_DIM * MAX_KERNEL_DIM);

  logic                                 en;
  logic [KDIM_W-1:0]                    kernel_dim;
  logic [NUM_UNITS-1:0][DATA_WIDTH-1:0] pixel_in;
  logic                                 pixel_valid;
  logic                                 step;
  logic                                 w_we;
  logic [ADDR_W-1:0]                    w_addr;
  logic [DATA_WIDTH-1:0]                w_data;
  logic [NUM_UNITS-1:0][DATA_WIDTH-1:0] result;
  logic                                 result_valid;
  logic                                 result_ready;
  logic                                 busy;

  modport master (
    output en, kernel_dim, pixel_in, pixel_valid, w_we, w_addr, w_data, result_ready,
    input  step, result, result_valid, busy
  );

  modport slave (
    input  en, kernel_dim, pixel_in, pixel_valid, w_we, w_addr, w_data, result_ready,
    output step, result, result_valid, busy
  );

endinterface

// File: rtl/mac_lane.sv
// One window lane: signed full-precision multiply-accumulate and the fold of the
// accumulator to DATA_WIDTH. Define MAC_SATURATE_EN to clamp instead of truncate.
module mac_lane import ttpu_pkg::*; #(
  parameter int unsigned DATA_WIDTH = DefDataWidth,
  parameter int unsigned ACC_WIDTH  = acc_width(DefDataWidth, DefMaxKernelDim)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         i_clear,
  input  logic                         i_acc_en,
  input  logic                         i_load,
  input  logic signed [DATA_WIDTH-1:0] i_pixel,
  input  logic signed [DATA_WIDTH-1:0] i_weight,
  output logic signed [DATA_WIDTH-1:0] o_result
);

  localparam int unsigned ProdW = 2 * DATA_WIDTH;

  logic signed [ProdW-1:0]      w_prod;
  logic signed [ACC_WIDTH-1:0]  w_prod_ext;
  logic signed [ACC_WIDTH-1:0]  r_acc;
  logic signed [DATA_WIDTH-1:0] w_fold;
  logic signed [DATA_WIDTH-1:0] r_result;

  assign w_prod     = i_pixel * i_weight;
  assign w_prod_ext = {{(ACC_WIDTH - ProdW){w_prod[ProdW-1]}}, w_prod};

`ifdef MAC_SATURATE_EN
  localparam logic signed [ACC_WIDTH-1:0] AccMax =
    {{(ACC_WIDTH - DATA_WIDTH + 1){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] AccMin =
    {{(ACC_WIDTH - DATA_WIDTH + 1){1'b1}}, {(DATA_WIDTH - 1){1'b0}}};

  always_comb begin
    w_fold = r_acc[DATA_WIDTH-1:0];
    if (r_acc > AccMax) begin
      w_fold = AccMax[DATA_WIDTH-1:0];
    end else if (r_acc < AccMin) begin
      w_fold = AccMin[DATA_WIDTH-1:0];
    end
  end
`else
  assign w_fold = r_acc[DATA_WIDTH-1:0];
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc    <= '0;
      r_result <= '0;
    end else begin
      if (i_clear) begin
        r_acc <= '0;
      end else if (i_acc_en) begin
        r_acc <= r_acc + w_prod_ext;
      end
      if (i_load) begin
        r_result <= w_fold;
      end
    end
  end

  assign o_result = r_result;

endmodule

// File: rtl/window_mac_unit.sv
// Convolution window MAC: NUM_UNITS lanes share one K*K weight bank and step through
// the window one tap per valid pixel. Optional macro: MAC_SATURATE_EN (result clamp).
module window_mac_unit import ttpu_pkg::*; #(
  parameter int unsigned DATA_WIDTH     = DefDataWidth,
  parameter int unsigned NUM_UNITS      = 2,
  parameter int unsigned MAX_KERNEL_DIM = DefMaxKernelDim
) (
  input logic              clk,
  input logic              reset,
  window_mac_unit_if.slave bus
);

  localparam int unsigned KDIM_W = $clog2(MAX_KERNEL_DIM) + 1;
  localparam int unsigned ADDR_W = $clog2(MAX_KERNEL_DIM * MAX_KERNEL_DIM);
  localparam int unsigned DEPTH  = MAX_KERNEL_DIM * MAX_KERNEL_DIM;
  localparam int unsigned ACC_W  = acc_width(DATA_WIDTH, MAX_KERNEL_DIM);

  mac_state_e                           r_state;
  logic [ADDR_W-1:0]                    r_tap;
  logic [ADDR_W-1:0]                    r_last_tap;
  logic                                 r_result_valid;
  logic signed [DATA_WIDTH-1:0]         r_weights [DEPTH];

  logic                                 w_kdim_ok;
  logic                                 w_start;
  logic                                 w_step;
  logic                                 w_load;
  logic [2*KDIM_W-1:0]                  w_kk;
  logic signed [DATA_WIDTH-1:0]         w_weight;
  logic [NUM_UNITS-1:0][DATA_WIDTH-1:0] w_result;

  assign w_kdim_ok = (bus.kernel_dim != '0) &&
                     (bus.kernel_dim <= KDIM_W'(MAX_KERNEL_DIM));
  assign w_start   = (r_state == StIdle) && bus.en && w_kdim_ok;
  assign w_step    = (r_state == StAccum) && bus.pixel_valid;
  // Result is captured on the first DONE cycle, after the final tap has landed.
  assign w_load    = (r_state == StDone) && !r_result_valid;
  assign w_kk      = {{KDIM_W{1'b0}}, bus.kernel_dim} * {{KDIM_W{1'b0}}, bus.kernel_dim};
  assign w_weight  = r_weights[r_tap];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= StIdle;
      r_tap          <= '0;
      r_last_tap     <= '0;
      r_result_valid <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_start) begin
            r_state    <= StAccum;
            r_tap      <= '0;
            r_last_tap <= ADDR_W'(w_kk - 1);
          end
        end
        StAccum: begin
          if (bus.pixel_valid) begin
            if (r_tap == r_last_tap) begin
              r_state <= StDone;
            end else begin
              r_tap <= r_tap + ADDR_W'(1);
            end
          end
        end
        StDone: begin
          if (!r_result_valid) begin
            r_result_valid <= 1'b1;
          end else if (bus.result_ready) begin
            r_result_valid <= 1'b0;
            r_state        <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  // Weight bank survives reset so a loaded kernel can be reused across aborts.
  always_ff @(posedge clk) begin
    if ((r_state == StIdle) && bus.w_we) begin
      r_weights[bus.w_addr] <= bus.w_data;
    end
  end

  for (genvar g = 0; g < NUM_UNITS; g++) begin : g_lane
    mac_lane #(
      .DATA_WIDTH (DATA_WIDTH),
      .ACC_WIDTH  (ACC_W)
    ) u_lane (
      .clk      (clk),
      .reset    (reset),
      .i_clear  (w_start),
      .i_acc_en (w_step),
      .i_load   (w_load),
      .i_pixel  (bus.pixel_in[g]),
      .i_weight (w_weight),
      .o_result (w_result[g])
    );
  end

  assign bus.step         = w_step;
  assign bus.busy         = (r_state != StIdle);
  assign bus.result_valid = r_result_valid;
  assign bus.result       = w_result;

endmodule
